// File: rtl/bridge_psram_writer_if.sv
// rtl/bridge_psram_writer_if.sv - word write request bus towards the PSRAM controller
interface bridge_psram_writer_if #(
  parameter int AW = 22
);
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_data;

  modport master (
    output mem_valid,
    output mem_addr,
    output mem_data,
    input  mem_ready
  );

  modport slave (
    input  mem_valid,
    input  mem_addr,
    input  mem_data,
    output mem_ready
  );
endinterface

// File: rtl/bridge_psram_writer.sv
// rtl/bridge_psram_writer.sv - buffers windowed 32-bit bridge writes, issues them as two 16-bit PSRAM words
module bridge_psram_writer #(
  parameter int         DEPTH = 16,
  parameter logic [7:0] BASE  = 8'h00,
  parameter int         AW    = 22
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_wr,
  input  logic [31:0]              in_addr,
  input  logic [31:0]              in_data,
  bridge_psram_writer_if.master    mem,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     idle,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int WW = AW - 1;
  localparam int EW = WW + 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LO,
    S_HI
  } state_t;

  logic [EW-1:0] fifo [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  state_t        state;
  logic [WW-1:0] hold_w;
  logic [15:0]   hold_hi;

  logic          accept;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic [EW-1:0] head;
  logic          unused_addr_bits;

  assign accept = in_wr && (in_addr[31:24] == BASE);
  assign empty  = (level == '0);
  assign full   = (level == LW'(DEPTH));
  assign pop    = (state == S_IDLE) && !empty;
  // A full FIFO still takes a write when the FSM frees a slot in the same cycle
  assign push   = accept && (!full || pop);
  assign head   = fifo[rd_ptr];
  assign idle   = (state == S_IDLE) && empty;

  assign unused_addr_bits = ^{in_addr[23:AW+1], in_addr[1:0]};

  always_ff @(posedge clock) begin
    if (push) begin
      fifo[wr_ptr] <= {in_addr[AW:2], in_data};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      overflow      <= 1'b0;
      state         <= S_IDLE;
      hold_w        <= '0;
      hold_hi       <= '0;
      mem.mem_valid <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_data  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end
      if (accept && full && !pop) begin
        overflow <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (!empty) begin
            hold_w        <= head[EW-1:32];
            hold_hi       <= head[31:16];
            mem.mem_valid <= 1'b1;
            mem.mem_addr  <= {head[EW-1:32], 1'b0};
            mem.mem_data  <= head[15:0];
            state         <= S_LO;
          end
        end
        S_LO: begin
          if (mem.mem_ready) begin
            mem.mem_addr <= {hold_w, 1'b1};
            mem.mem_data <= hold_hi;
            state        <= S_HI;
          end
        end
        S_HI: begin
          if (mem.mem_ready) begin
            mem.mem_valid <= 1'b0;
            state         <= S_IDLE;
          end
        end
        default: begin
          mem.mem_valid <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bridge_psram_writer.sv
// tb/tb_bridge_psram_writer.sv - directed self-checking bench for bridge_psram_writer
module tb_bridge_psram_writer;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_wr;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [4:0]  level;
  logic        idle;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];

  bridge_psram_writer_if #(.AW(22)) mem_if ();

  bridge_psram_writer #(
    .DEPTH(16),
    .BASE (8'h00),
    .AW   (22)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .in_wr   (in_wr),
    .in_addr (in_addr),
    .in_data (in_data),
    .mem     (mem_if),
    .level   (level),
    .idle    (idle),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (mem_if.mem_valid && mem_if.mem_ready) begin
      got_q.push_back({26'b0, mem_if.mem_addr, mem_if.mem_data});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_words(input int n);
    for (int k = 0; k < 300; k++) begin
      if (got_q.size() >= n) break;
      cyc();
    end
    repeat (4) cyc();
  endtask

  task automatic compare_words(input string tag);
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
    end
  endtask

  initial begin
    bit found;
    reset            = 1'b1;
    in_wr            = 1'b0;
    in_addr          = '0;
    in_data          = '0;
    mem_if.mem_ready = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
    @(negedge clock);
    check("rst_valid", 64'(mem_if.mem_valid), 64'd0);
    check("rst_addr", 64'(mem_if.mem_addr), 64'd0);
    check("rst_data", 64'(mem_if.mem_data), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_ovf", 64'(overflow), 64'd0);

    // single write, ready held high
    cyc();
    in_wr = 1'b1; in_addr = 32'h0000_0010; in_data = 32'hDEAD_BEEF; mem_if.mem_ready = 1'b1;
    cyc();
    in_wr = 1'b0;
    @(negedge clock);
    check("t1_lat_valid0", 64'(mem_if.mem_valid), 64'd0);
    check("t1_level1", 64'(level), 64'd1);
    check("t1_idle0", 64'(idle), 64'd0);
    cyc();
    @(negedge clock);
    check("t1_lo", {mem_if.mem_valid, mem_if.mem_addr, mem_if.mem_data}, {1'b1, 22'h8, 16'hBEEF});
    cyc();
    @(negedge clock);
    check("t1_hi", {mem_if.mem_valid, mem_if.mem_addr, mem_if.mem_data}, {1'b1, 22'h9, 16'hDEAD});
    cyc();
    @(negedge clock);
    check("t1_done_valid", 64'(mem_if.mem_valid), 64'd0);
    check("t1_done_idle", 64'(idle), 64'd1);

    // backpressure in LO
    cyc();
    mem_if.mem_ready = 1'b0;
    in_wr = 1'b1; in_addr = 32'h0000_0100; in_data = 32'h1234_5678;
    cyc();
    in_wr = 1'b0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check($sformatf("t2_hold%0d", i), {mem_if.mem_valid, mem_if.mem_addr, mem_if.mem_data},
            {1'b1, 22'h80, 16'h5678});
      cyc();
    end
    mem_if.mem_ready = 1'b1;
    @(negedge clock);
    check("t2_lo_last", {mem_if.mem_valid, mem_if.mem_addr, mem_if.mem_data}, {1'b1, 22'h80, 16'h5678});
    cyc();
    @(negedge clock);
    check("t2_hi", {mem_if.mem_valid, mem_if.mem_addr, mem_if.mem_data}, {1'b1, 22'h81, 16'h1234});
    cyc();
    @(negedge clock);
    check("t2_done", {mem_if.mem_valid, idle}, {1'b0, 1'b1});

    // write outside the window
    cyc();
    in_wr = 1'b1; in_addr = 32'h1000_0000; in_data = 32'hCAFE_F00D;
    cyc();
    in_wr = 1'b0;
    @(negedge clock);
    check("t3_level", 64'(level), 64'd0);
    cyc();
    @(negedge clock);
    check("t3_valid", 64'(mem_if.mem_valid), 64'd0);
    check("t3_ovf", 64'(overflow), 64'd0);
    check("t3_idle", 64'(idle), 64'd1);

    // fill and overflow: 18 writes, 17 kept (16 in FIFO + 1 in FSM)
    cyc();
    got_q.delete(); exp_q.delete();
    mem_if.mem_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      in_wr   = 1'b1;
      in_addr = 32'h0000_1000 + 32'(i * 4);
      in_data = {16'hC000 + 16'(i), 16'h0A00 + 16'(i)};
      if (i < 17) begin
        exp_q.push_back({26'b0, 22'h800 + 22'(2 * i), 16'h0A00 + 16'(i)});
        exp_q.push_back({26'b0, 22'h801 + 22'(2 * i), 16'hC000 + 16'(i)});
      end
      cyc();
      if (i == 16) begin
        @(negedge clock);
        check("t4_level_full", 64'(level), 64'd16);
        check("t4_ovf_before", 64'(overflow), 64'd0);
      end
    end
    in_wr = 1'b0;
    @(negedge clock);
    check("t4_level_peak", 64'(level), 64'd16);
    check("t4_ovf_set", 64'(overflow), 64'd1);
    cyc();
    mem_if.mem_ready = 1'b1;
    wait_words(34);
    compare_words("t4");
    @(negedge clock);
    check("t4_drained", {level, idle, overflow}, {5'd0, 1'b1, 1'b1});

    // full with a same-cycle pop
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clock);
    check("t5_ovf_cleared", 64'(overflow), 64'd0);
    cyc();
    got_q.delete(); exp_q.delete();
    mem_if.mem_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      in_wr   = 1'b1;
      in_addr = 32'h0000_2000 + 32'(i * 4);
      in_data = {16'hB000 + 16'(i), 16'h0B00 + 16'(i)};
      exp_q.push_back({26'b0, 22'h1000 + 22'(2 * i), 16'h0B00 + 16'(i)});
      exp_q.push_back({26'b0, 22'h1001 + 22'(2 * i), 16'hB000 + 16'(i)});
      cyc();
    end
    in_wr = 1'b0;
    @(negedge clock);
    check("t5_level_full", 64'(level), 64'd16);
    cyc();
    mem_if.mem_ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (!mem_if.mem_valid) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    check("t5_reached_idle", 64'(found), 64'd1);
    in_wr = 1'b1; in_addr = 32'h0000_2044; in_data = 32'h7777_5555;
    exp_q.push_back({26'b0, 22'h1022, 16'h5555});
    exp_q.push_back({26'b0, 22'h1023, 16'h7777});
    cyc();
    in_wr = 1'b0;
    @(negedge clock);
    check("t5_level_same", 64'(level), 64'd16);
    check("t5_ovf_clear", 64'(overflow), 64'd0);
    wait_words(36);
    compare_words("t5");

    // reset during HI with four entries queued
    cyc();
    mem_if.mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_wr   = 1'b1;
      in_addr = 32'h0000_3000 + 32'(i * 4);
      in_data = 32'h0101_0101 * 32'(i + 1);
      cyc();
    end
    in_wr = 1'b0;
    cyc();
    mem_if.mem_ready = 1'b1;
    cyc();
    mem_if.mem_ready = 1'b0;
    @(negedge clock);
    check("t6_in_hi", {mem_if.mem_valid, mem_if.mem_addr, mem_if.mem_data}, {1'b1, 22'h1801, 16'h0101});
    check("t6_level4", 64'(level), 64'd4);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clock);
    check("t6_rst", {mem_if.mem_valid, level, idle, overflow}, {1'b0, 5'd0, 1'b1, 1'b0});
    cyc();
    got_q.delete();
    mem_if.mem_ready = 1'b1;
    repeat (10) cyc();
    @(negedge clock);
    check("t6_no_words", 64'(got_q.size()), 64'd0);
    check("t6_idle", {mem_if.mem_valid, idle}, {1'b0, 1'b1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bridge_psram_writer.md
Name: bridge_psram_writer

Overview:
Sits between the bridge write port and the PSRAM controller inside Main, in the system clock domain. It accepts 32-bit bridge writes that hit its address window and buffers them in a FIFO. Each buffered write is split into two 16-bit little-endian word writes, issued to the PSRAM controller over a valid/ready handshake. It reports idle/level/overflow status so the core can hold off running until data-slot loading has drained.

Parameters:
DEPTH, 16, FIFO entries; power of two, at least 2.
BASE, 8'h00, match value for in_addr[31:24].
AW, 22, PSRAM word-address width.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
in_wr  in  1  bridge write strobe, one cycle per write, already synchronised to clock
in_addr  in  32  bridge byte address
in_data  in  32  bridge write data, little-endian
mem_valid  out  1  word write request to PSRAM controller
mem_ready  in  1  controller accepts request this cycle
mem_addr  out  AW  PSRAM word address
mem_data  out  16  PSRAM word data
level  out  $clog2(DEPTH)+1  current FIFO occupancy
idle  out  1  FIFO empty and no word pending
overflow  out  1  sticky flag: a write was dropped

Behaviour:
- Reset values: mem_valid=0, mem_addr=0, mem_data=0, level=0, idle=1, overflow=0. FIFO pointers are cleared. FSM goes to IDLE.
- Accept condition: in_wr=1 and in_addr[31:24]==BASE. Non-matching writes are ignored and do not set overflow.
- FIFO entry: {in_addr[AW:2], in_data}. in_addr[1:0] is ignored.
- Push when accepted and (not full, or a pop occurs in the same cycle). If accepted while full with no same-cycle pop: the write is dropped and overflow is set, sticky until reset.
- level: +1 on push, -1 on pop, unchanged when both occur. Registered; updates the cycle after the event.
- FSM states: IDLE, LO, HI.
  - IDLE: if FIFO not empty, pop the head into the holding register (addr w, data d) and go to LO next cycle. Pop happens in IDLE only.
  - LO: mem_valid=1, mem_addr={w,1'b0}, mem_data=d[15:0]. On mem_ready, go to HI.
  - HI: mem_valid=1, mem_addr={w,1'b1}, mem_data=d[31:16]. On mem_ready, go to IDLE.
- mem_valid, mem_addr and mem_data are registered. They stay stable while mem_valid=1 and mem_ready=0; no retraction.
- mem_ready while mem_valid=0 is ignored.
- Throughput: 3 cycles per 32-bit write with mem_ready held high (IDLE pop, LO, HI). Latency from in_wr to first mem_valid is 2 cycles with the FIFO empty.
- idle=1 iff FSM in IDLE and FIFO empty, evaluated combinationally from registered state.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are derived from level.
- Reset mid-transfer: a pending word is abandoned and mem_valid drops the cycle after reset is asserted. Buffered entries are discarded.
- Address arithmetic: word address is exactly {in_addr[AW:2], half}, no carry. Writes above the window are masked by the BASE compare only.

Test Plan:
1. Single write: in_addr=0x0000_0010, in_data=0xDEAD_BEEF, mem_ready=1 -> mem_addr 0x8/data 0xBEEF, then mem_addr 0x9/data 0xDEAD. mem_valid first seen 2 cycles after in_wr. idle returns to 1.
2. Backpressure: mem_ready=0 for 5 cycles during LO -> mem_valid/addr/data held constant. The HI word follows only after ready is seen.
3. Window filter: write with in_addr=0x1000_0000, BASE=0 -> no mem_valid, level stays 0, overflow stays 0.
4. Fill and overflow: mem_ready=0, 18 back-to-back matching writes, DEPTH=16 -> level peaks at 16 (one more entry is held in the FSM), the 18th write sets overflow. After releasing mem_ready, exactly 34 words arrive in order.
5. Full with simultaneous pop: level=16, FSM popping in the same cycle as in_wr -> write accepted, level stays 16, overflow=0.
6. Reset mid-stream: assert reset during HI with 4 entries queued -> next cycle mem_valid=0, level=0, idle=1, overflow=0. No further words are issued.
